// File: rtl/mult_rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_rs_pkg
//  Description : Shared defaults and entry layout for the multiply reservation
//                station.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_rs_pkg;

    localparam int RS_ENTRIES = 4;
    localparam int RS_TAGW    = 4;
    localparam int RS_DW      = 8;

    typedef struct packed {
        logic [7:0]                   operand;
        logic [1:0][RS_TAGW-1:0]      tag;
        logic [1:0]                   rdy;
        logic [1:0][RS_DW-1:0]        val;
        logic [7:0]                   wbs;
        logic [7:0]                   flags;
        logic [RS_TAGW-1:0]           robid;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/rs_oldest_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rs_oldest_pick
//  Description : Grants the candidate that has no older candidate, using an
//                age matrix where age[i][j]=1 means entry i is older than j.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_oldest_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]        i_cand,
    input  logic [N-1:0][N-1:0] i_age,
    output logic [N-1:0]        o_grant,
    output logic                o_valid
);

    logic [N-1:0] w_older;

    always_comb begin
        w_older = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i_cand[j] && i_age[j][i]) w_older[i] = 1'b1;
            end
        end
    end

    assign o_grant = i_cand & ~w_older;
    assign o_valid = |o_grant;

endmodule
`default_nettype wire

// File: rtl/mult_rs.sv
`default_nettype none
// ============================================================================
//  Module      : mult_rs
//  Description : Multiply reservation station: dispatch, CDB wakeup/bypass and
//                oldest-ready issue to a single multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_rs
    import mult_rs_pkg::*;
#(
    parameter int ENTRIES = RS_ENTRIES,
    parameter int TAGW    = RS_TAGW,
    parameter int DW      = RS_DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         disp_valid,
    input  logic [7:0]                   disp_operand,
    input  logic [1:0][TAGW-1:0]         disp_tags,
    input  logic [1:0]                   disp_rdy,
    input  logic [1:0][DW-1:0]           disp_vals,
    input  logic [7:0]                   disp_wbs,
    input  logic [7:0]                   disp_flags,
    input  logic [TAGW-1:0]              disp_robid,
    input  logic                         cdb_valid,
    input  logic [TAGW-1:0]              cdb_id,
    input  logic [DW-1:0]                cdb_val,
    input  logic                         flush,
    input  logic                         fu_busy,
    output logic                         full,
    output logic [$clog2(ENTRIES+1)-1:0] count,
    output logic                         issue_transmit,
    output logic [7:0]                   issue_operand,
    output logic [1:0][DW-1:0]           issue_depvals,
    output logic [7:0]                   issue_wbs,
    output logic [7:0]                   issue_flags,
    output logic [TAGW-1:0]              issue_robid
);

    localparam int IW = $clog2(ENTRIES);
    localparam int CW = $clog2(ENTRIES+1);

    logic [ENTRIES-1:0]              r_valid;
    rs_entry_t                       r_ent [ENTRIES];
    logic [ENTRIES-1:0][ENTRIES-1:0] r_age;
    logic [ENTRIES-1:0][ENTRIES-1:0] w_age_nxt;

    logic [ENTRIES-1:0] w_cand;
    logic [ENTRIES-1:0] w_grant;
    logic               w_pick_valid;
    logic               w_issue;
    logic               w_alloc;
    logic [IW-1:0]      w_issue_idx;
    logic [IW-1:0]      w_free_idx;
    logic [CW-1:0]      w_count;
    rs_entry_t          w_new_ent;

    always_comb begin
        w_cand = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_cand[i] = r_valid[i] & (&r_ent[i].rdy);
        end
    end

    rs_oldest_pick #(
        .N (ENTRIES)
    ) u_pick (
        .i_cand  (w_cand),
        .i_age   (r_age),
        .o_grant (w_grant),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_count     = '0;
        w_free_idx  = '0;
        w_issue_idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = IW'(i);
            if (w_grant[i])  w_issue_idx = IW'(i);
            w_count = w_count + CW'(r_valid[i]);
        end
    end

    assign full    = &r_valid;
    assign count   = w_count;
    assign w_alloc = disp_valid & ~full & ~flush;
    // The issue_transmit term covers the cycle before fu_busy rises.
    assign w_issue = w_pick_valid & ~fu_busy & ~issue_transmit & ~flush;

    // New entry, with any source that matches the same-cycle broadcast captured.
    always_comb begin
        w_new_ent.operand = disp_operand;
        w_new_ent.tag     = disp_tags;
        w_new_ent.rdy     = disp_rdy;
        w_new_ent.val     = disp_vals;
        w_new_ent.wbs     = disp_wbs;
        w_new_ent.flags   = disp_flags;
        w_new_ent.robid   = disp_robid;
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid && !disp_rdy[k] && disp_tags[k] == cdb_id) begin
                w_new_ent.val[k] = cdb_val;
                w_new_ent.rdy[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_age_nxt = r_age;
        for (int j = 0; j < ENTRIES; j++) begin
            for (int c = 0; c < ENTRIES; c++) begin
                if (w_alloc && c == int'(w_free_idx)) w_age_nxt[j][c] = r_valid[j];
                if (w_alloc && j == int'(w_free_idx)) w_age_nxt[j][c] = 1'b0;
                if (w_issue && (j == int'(w_issue_idx) || c == int'(w_issue_idx)))
                    w_age_nxt[j][c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid        <= '0;
            r_age          <= '0;
            issue_transmit <= 1'b0;
            issue_operand  <= '0;
            issue_depvals  <= '0;
            issue_wbs      <= '0;
            issue_flags    <= '0;
            issue_robid    <= '0;
            for (int i = 0; i < ENTRIES; i++) r_ent[i] <= '0;
        end else if (flush) begin
            r_valid        <= '0;
            r_age          <= '0;
            issue_transmit <= 1'b0;
        end else begin
            r_age          <= w_age_nxt;
            issue_transmit <= w_issue;
            for (int i = 0; i < ENTRIES; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if (r_valid[i] && cdb_valid && !r_ent[i].rdy[k] &&
                        r_ent[i].tag[k] == cdb_id) begin
                        r_ent[i].val[k] <= cdb_val;
                        r_ent[i].rdy[k] <= 1'b1;
                    end
                end
            end
            if (w_issue) begin
                issue_operand        <= r_ent[w_issue_idx].operand;
                issue_depvals        <= r_ent[w_issue_idx].val;
                issue_wbs            <= r_ent[w_issue_idx].wbs;
                issue_flags          <= r_ent[w_issue_idx].flags;
                issue_robid          <= r_ent[w_issue_idx].robid;
                r_valid[w_issue_idx] <= 1'b0;
            end
            // The allocated slot is never the issuing one, so the writes don't collide.
            if (w_alloc) begin
                r_valid[w_free_idx] <= 1'b1;
                r_ent[w_free_idx]   <= w_new_ent;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mult_rs.md
Name: mult_rs

Overview:
- Reservation station that sits directly upstream of the multiply functional unit.
- Accepts dispatched multiply ops whose sources may still be pending ROB results.
- Wakes those sources by snooping the CDB.
- Issues the oldest fully-ready op to the multiplier whenever the multiplier is not busy.
- Carries operand, wbs, flags and robid through unchanged so the multiplier and its output stage can retire to the ROB and CDB.

Parameters:
- ENTRIES, 4: number of station slots (2..8).
- TAGW, 4: ROB id / source tag width.
- DW, 8: data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- disp_valid  in  1  dispatch request; accepted only when full==0
- disp_operand  in  8  opcode/operand byte, passed through
- disp_tags  in  [1:0][TAGW]  source ROB tags
- disp_rdy  in  [1:0]  source already has a value
- disp_vals  in  [1:0][DW]  source values (valid where disp_rdy=1)
- disp_wbs  in  8  writeback selector, passed through
- disp_flags  in  8  flags, passed through (bit7=1 suppresses CDB write downstream)
- disp_robid  in  TAGW  destination ROB id
- cdb_valid  in  1  CDB broadcast valid
- cdb_id  in  TAGW  broadcasting ROB id
- cdb_val  in  DW  broadcast value
- flush  in  1  synchronous squash of all entries
- fu_busy  in  1  multiplier busy (compute or output stage)
- full  out  1  no free slot
- count  out  $clog2(ENTRIES+1)  occupied slots
- issue_transmit  out  1  one-cycle issue pulse to the multiplier
- issue_operand  out  8  operand of the issued op
- issue_depvals  out  [1:0][DW]  resolved source values
- issue_wbs  out  8  wbs of the issued op
- issue_flags  out  8  flags of the issued op
- issue_robid  out  TAGW  robid of the issued op

Behaviour:
- Reset (async, rst=1): all entry valid bits=0, age matrix=0. Outputs: issue_transmit=0, issue_* data=0, full=0, count=0.
- Entry state: valid, operand, tag[2], rdy[2], val[2], wbs, flags, robid.
- full and count are combinational from the registered valid bits. A slot freed by issue in cycle t is reusable from cycle t+1 only.
- Dispatch: if disp_valid && !full, allocate the lowest-index free slot. If disp_valid && full, drop the request; the dispatcher must hold it.
- Dispatch/CDB bypass: if cdb_valid and disp_tags[k]==cdb_id for a source with disp_rdy[k]=0, capture cdb_val and set rdy[k]=1 in the same edge.
- Wakeup: for every valid entry, any source with rdy=0 and tag==cdb_id while cdb_valid gets val=cdb_val and rdy=1. Both sources may wake on the same broadcast.
- Ready flags are registered. An entry woken at edge E can issue at edge E+1 at the earliest.
- Age matrix: age[i][j]=1 means entry i is older than entry j.
  - On allocating slot k: age[j][k]=1 for every valid j, and age[k][*]=0.
  - On free: clear row and column.
- Issue select: an entry is a candidate when it is valid with both rdy=1. Pick the candidate with no older candidate.
- Issue fires at an edge when a candidate exists && !fu_busy && !issue_transmit && !flush.
  - issue_* data is registered from the chosen entry, issue_transmit=1 for exactly one cycle, and the entry is freed at the same edge.
  - The !issue_transmit guard covers the one cycle in which the multiplier has latched but fu_busy has not yet risen. Issues are therefore never back-to-back.
- issue_* data holds its last value while issue_transmit=0.
- Simultaneous dispatch+issue: both occur, count nets 0.
- Simultaneous dispatch+issue in a full station: dispatch is rejected, issue occurs.
- flush: at the edge, clear all valid bits and the age matrix, drop any dispatch, force issue_transmit=0. flush has priority over everything.
- Reset mid-operation clears state immediately. No partial issue may remain.

Decomposition:
- Shared package mult_rs_pkg holds ENTRIES, TAGW and DW defaults, and rs_entry_t as a packed struct of the entry fields.
- One sub-module, rs_oldest_pick: combinational age-matrix oldest-candidate selector, taking the candidate vector and the age matrix and producing a one-hot grant plus a valid flag.

Test Plan:
- Ready dispatch: dispatch with disp_rdy=2'b11, vals 3 and 5, robid 2, fu_busy=0 -> issue_transmit pulses 1 cycle later with depvals {3,5}, robid 2; count returns to 0.
- Pending wakeup: dispatch with tag0=6 not ready, vals1=9 ready; 3 cycles later CDB id 6 val 7 -> issue one cycle after the broadcast with depvals {7,9}. Same flow with a CDB id of 5 -> no issue.
- Bypass: dispatch with tag1=4 not ready in the same cycle as CDB id 4 val 0x20 -> entry issues next cycle with depvals[1]=0x20.
- Age order: fill 4 entries robid 1..4, all waiting on tag 8, fu_busy=0; CDB id 8 -> issues in order 1,2,3,4 with fu_busy modelled as busy for 10 cycles after each issue; full=1 before the first issue; a dispatch while full is dropped.
- Busy gating: fu_busy=1 with a ready entry -> no issue. Drop fu_busy -> exactly one pulse, and no second pulse the following cycle even if fu_busy is still 0.
- Flush/reset: 3 valid entries, flush -> count=0, no issue next cycle. Async rst mid-issue cycle -> issue_transmit falls immediately.
